sha256_hash_ctrl: RTL and testbench

SHA256_HASH_CTRL -- requirements
Module: sha256_hash_ctrl

---
 rtl/sha256_hash_ctrl_if.sv | 29 ++
 rtl/sha256_hash_ctrl.sv | 145 ++++++++++++++
 tb/tb_sha256_hash_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_hash_ctrl_if.sv
// Block-input, round-core and digest-output signals of sha256_hash_ctrl.
// slave is the controller's view; master is the surrounding system (block source, round core, digest sink).
interface sha256_hash_ctrl_if;
   logic           blk_valid;
   logic           blk_ready;
   logic [511:0]   blk_data;
   logic           blk_first;
   logic           blk_last;
   logic           core_start;
   logic [255:0]   core_h_in;
   logic [2047:0]  core_w;
   logic           core_done;
   logic [255:0]   core_h_out;
   logic           dig_valid;
   logic           dig_ready;
   logic [255:0]   digest;
   logic           busy;
   logic           err;

   modport slave (
      input  blk_valid, blk_data, blk_first, blk_last, core_done, core_h_out, dig_ready,
      output blk_ready, core_start, core_h_in, core_w, dig_valid, digest, busy, err
   );

   modport master (
      output blk_valid, blk_data, blk_first, blk_last, core_done, core_h_out, dig_ready,
      input  blk_ready, core_start, core_h_in, core_w, dig_valid, digest, busy, err
   );
endinterface

// File: rtl/sha256_hash_ctrl.sv
// SHA-256 block controller: 48-cycle schedule expansion, round-core handshake, H chaining; digest 2 edges after core_done,
// blocks refused outside IDLE, digest held until dig_ready. Define SHA256_HASH_CTRL_TIMEOUT_EN for a sticky core timeout.
module sha256_hash_ctrl #(
   parameter int TIMEOUT_CYCLES = 80
) (
   input logic               clk,
   input logic               reset,
   sha256_hash_ctrl_if.slave bus
);
   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [2:0] {IDLE, EXPAND, START, WAIT, ADD, OUT} state_t;

   state_t           state;
   logic [63:0][31:0] w;
   logic [7:0][31:0]  h;
   logic [7:0][31:0]  h_out;
   logic [255:0]      digest_q;
   logic [5:0]        exp_cnt;
   logic              last_q;
   logic              blk_ready_q;
   logic              core_start_q;
   logic              dig_valid_q;
   logic              busy_q;
   logic [31:0]       w_new;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // w is a shift register: the newest word sits in w[0], so W[t-2], W[t-7], W[t-15], W[t-16]
   // are always at fixed taps, and after 48 shifts W[0] has reached the top of core_w.
   assign w_new = sig1(w[1]) + w[6] + sig0(w[14]) + w[15];
   assign h_out = bus.core_h_out;

`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt;
   logic            err_q;
   assign bus.err = err_q;
`else
   assign bus.err = 1'b0;
   // The timeout length only matters when the timeout is built in; keep the parameter range meaningful.
   if (TIMEOUT_CYCLES < 2) begin : g_timeout_cfg_check
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         blk_ready_q  <= 1'b1;
         core_start_q <= 1'b0;
         dig_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         h            <= IV;
         w            <= '0;
         digest_q     <= '0;
         exp_cnt      <= '0;
         last_q       <= 1'b0;
`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
         to_cnt       <= '0;
         err_q        <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.blk_valid) begin
                  w[15:0]     <= bus.blk_data;
                  if (bus.blk_first) h <= IV;
                  last_q      <= bus.blk_last;
                  exp_cnt     <= '0;
                  blk_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state       <= EXPAND;
               end
            end
            EXPAND: begin
               w       <= {w[62:0], w_new};
               exp_cnt <= exp_cnt + 1'b1;
               if (exp_cnt == 6'd47) begin
                  core_start_q <= 1'b1;
                  state        <= START;
               end
            end
            START: begin
               core_start_q <= 1'b0;
               state        <= WAIT;
`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
               to_cnt       <= '0;
`endif
            end
            WAIT: begin
               if (bus.core_done) begin
                  state <= ADD;
               end
`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
               // Last WAIT edge that still falls within TIMEOUT_CYCLES of the core_start cycle.
               else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 2)) begin
                  err_q       <= 1'b1;
                  blk_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
`endif
            end
            ADD: begin
               for (int i = 0; i < 8; i++) h[i] <= h[i] + h_out[i];
               if (last_q) begin
                  state <= OUT;
               end else begin
                  blk_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            OUT: begin
               if (!dig_valid_q) begin
                  dig_valid_q <= 1'b1;
                  digest_q    <= h;
               end else if (bus.dig_ready) begin
                  dig_valid_q <= 1'b0;
                  blk_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.blk_ready  = blk_ready_q;
   assign bus.core_start = core_start_q;
   assign bus.core_h_in  = h;
   assign bus.core_w     = w;
   assign bus.dig_valid  = dig_valid_q;
   assign bus.digest     = digest_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_sha256_hash_ctrl.sv
// Bench for sha256_hash_ctrl: plays the 64-round core with random latency and checks digests against
// published SHA-256 vectors and a behavioural SHA-256 model under random block/stall timing.
module tb_sha256_hash_ctrl;
   localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
   localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
   localparam logic [511:0] Q1_BLK    = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] Q2_BLK    = {480'd0, 32'h000001c0};
   localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
   localparam logic [255:0] Q_DIG     = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   int           checks = 0;
   int           failures = 0;
   int           cyc = 0;
   int           done_cyc = -100;
   int           core_lat_max = 4;
   bit           core_hang = 1'b0;
   logic [255:0] ref_chain = IV;
   logic [255:0] core_r;

   sha256_hash_ctrl_if bus();

   sha256_hash_ctrl #(.TIMEOUT_CYCLES(80)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // The 64 compression rounds over an already expanded schedule; returns the working variables a..h.
   function automatic logic [255:0] sha_rounds(input logic [255:0] hin, input logic [2047:0] wv);
      logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
      {a, b, c, d, e, f, g, hh} = hin;
      for (int t = 0; t < 64; t++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + wv[2047-32*t -: 32];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a, b, c, d, e, f, g, hh};
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]   wa [64];
      logic [2047:0] wv;
      logic [255:0]  r, res;
      for (int t = 0; t < 16; t++) wa[t] = blk[511-32*t -: 32];
      for (int t = 16; t < 64; t++)
         wa[t] = (rotr(wa[t-2], 17) ^ rotr(wa[t-2], 19) ^ (wa[t-2] >> 10)) + wa[t-7]
               + (rotr(wa[t-15], 7) ^ rotr(wa[t-15], 18) ^ (wa[t-15] >> 3)) + wa[t-16];
      for (int t = 0; t < 64; t++) wv[2047-32*t -: 32] = wa[t];
      r = sha_rounds(hin, wv);
      for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + r[255-32*i -: 32];
      return res;
   endfunction

   // Round core: random latency after core_start, random core_done/core_h_out noise while idle.
   initial begin
      bus.core_done  = 1'b0;
      bus.core_h_out = '0;
      forever begin
         @(posedge clk); #1;
         if (core_hang) begin
            bus.core_done = 1'b0;
         end else if (bus.core_start === 1'b1) begin
            bus.core_done = 1'b0;
            core_r = sha_rounds(bus.core_h_in, bus.core_w);
            repeat (1 + $urandom_range(0, core_lat_max)) @(posedge clk);
            #1;
            bus.core_done  = 1'b1;
            bus.core_h_out = core_r;
            @(posedge clk); #1;
            done_cyc      = cyc;
            bus.core_done = 1'b0;
         end else begin
            bus.core_done  = 1'($urandom_range(0, 1));
            bus.core_h_out = {$urandom(), $urandom(), $urandom(), $urandom(),
                              $urandom(), $urandom(), $urandom(), $urandom()};
         end
      end
   end

   task automatic send_block(input logic [511:0] d, input logic first, input logic last);
      int n = 0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      while (bus.blk_ready !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
      checks++;
      if (bus.blk_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_block: blk_ready=%b, required 1 within 2000 cycles", bus.blk_ready);
         return;
      end
      bus.blk_data  = d;
      bus.blk_first = first;
      bus.blk_last  = last;
      bus.blk_valid = 1'b1;
      @(posedge clk); #1;
      bus.blk_valid = 1'b0;
      bus.blk_first = 1'($urandom_range(0, 1));
      bus.blk_last  = 1'($urandom_range(0, 1));
      if (first) ref_chain = IV;
      ref_chain = ref_compress(ref_chain, d);
   endtask

   task automatic wait_digest(input logic [255:0] exp_dig, input string name, input int stall);
      int n = 0;
      int bad = 0;
      while (bus.dig_valid !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
      checks++;
      if (bus.dig_valid !== 1'b1) begin
         failures++;
         $display("FAIL %s dig_valid: got %b, required 1 within 2000 cycles", name, bus.dig_valid);
         return;
      end
      checks++;
      if (cyc != done_cyc + 2) begin
         failures++;
         $display("FAIL %s latency: dig_valid %0d edges after core_done, required 2", name, cyc - done_cyc);
      end
      checks++;
      if (bus.digest !== exp_dig) begin
         failures++;
         $display("FAIL %s digest: got %h required %h", name, bus.digest, exp_dig);
      end
      bus.blk_valid = 1'b1;
      bus.blk_data  = {16{$urandom()}};
      repeat (stall) begin
         @(posedge clk); #1;
         if (bus.dig_valid !== 1'b1 || bus.digest !== exp_dig || bus.blk_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL %s hold: %0d unstable cycles of %0d, required 0", name, bad, stall);
      end
      bus.blk_valid = 1'b0;
      bus.dig_ready = 1'b1;
      @(posedge clk); #1;
      bus.dig_ready = 1'b0;
      checks++;
      if (bus.dig_valid !== 1'b0 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.core_h_in !== exp_dig) begin
         failures++;
         $display("FAIL %s release: dig_valid=%b blk_ready=%b busy=%b h_in=%h, required 0 1 0 %h",
                  name, bus.dig_valid, bus.blk_ready, bus.busy, bus.core_h_in, exp_dig);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.core_start !== 1'b0 || bus.dig_valid !== 1'b0 || bus.err !== 1'b0) begin
         failures++;
         $display("FAIL reset flags: ready=%b busy=%b start=%b dvalid=%b err=%b, required 1 0 0 0 0",
                  bus.blk_ready, bus.busy, bus.core_start, bus.dig_valid, bus.err);
      end
      checks++;
      if (bus.digest !== 256'd0 || bus.core_w !== 2048'd0) begin
         failures++;
         $display("FAIL reset regs: digest=%h w_nonzero=%b, required zero", bus.digest, |bus.core_w);
      end
      checks++;
      if (bus.core_h_in !== IV) begin
         failures++;
         $display("FAIL reset chain: got %h required %h", bus.core_h_in, IV);
      end
      reset = 1'b0;
   endtask

   task automatic test_abc();
      send_block(ABC_BLK, 1'b1, 1'b1);
      wait_digest(ABC_DIG, "abc", 0);
   endtask

   task automatic test_empty();
      send_block(EMPTY_BLK, 1'b1, 1'b1);
      wait_digest(EMPTY_DIG, "empty", 2);
   endtask

   task automatic test_two_block();
      send_block(Q1_BLK, 1'b1, 1'b0);
      send_block(Q2_BLK, 1'b0, 1'b1);
      wait_digest(Q_DIG, "two_block", 1);
   endtask

   task automatic test_dig_stall();
      send_block(ABC_BLK, 1'b1, 1'b1);
      wait_digest(ABC_DIG, "stall20", 20);
   endtask

   task automatic test_reset_mid_expand();
      int bad = 0;
      send_block(ABC_BLK, 1'b1, 1'b1);
      repeat (29) begin
         @(posedge clk); #1;
         if (bus.dig_valid !== 1'b0 || bus.core_start !== 1'b0) bad++;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_chain = IV;
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL mid_reset early: %0d cycles with dig_valid/core_start, required 0", bad);
      end
      checks++;
      if (bus.blk_ready !== 1'b1 || bus.busy !== 1'b0 || bus.dig_valid !== 1'b0 || bus.core_h_in !== IV) begin
         failures++;
         $display("FAIL mid_reset state: ready=%b busy=%b dvalid=%b h_in=%h, required 1 0 0 IV",
                  bus.blk_ready, bus.busy, bus.dig_valid, bus.core_h_in);
      end
      send_block(ABC_BLK, 1'b1, 1'b1);
      wait_digest(ABC_DIG, "mid_reset_abc", 3);
   endtask

   task automatic test_random();
      logic [511:0] d;
      int           nb;
      logic         fst;
      for (int m = 0; m < 6; m++) begin
         nb           = $urandom_range(1, 3);
         fst          = 1'($urandom_range(0, 3) != 0);
         core_lat_max = $urandom_range(0, 12);
         for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom();
            send_block(d, (b == 0) ? fst : 1'b0, (b == nb - 1) ? 1'b1 : 1'b0);
         end
         wait_digest(ref_chain, "random", $urandom_range(0, 6));
      end
   endtask

`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      int n = 0;
      int bad = 0;
      core_hang = 1'b1;
      send_block(ABC_BLK, 1'b1, 1'b1);
      while (bus.core_start !== 1'b1 && n < 200) begin
         @(posedge clk); #1; n++;
         if (bus.dig_valid !== 1'b0) bad++;
      end
      checks++;
      if (bus.core_start !== 1'b1) begin
         failures++;
         $display("FAIL timeout start: core_start=%b, required 1 within 200 cycles", bus.core_start);
      end
      repeat (79) begin
         @(posedge clk); #1;
         if (bus.dig_valid !== 1'b0) bad++;
      end
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL timeout early: err=%b at 79 cycles, required 0", bus.err);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.err !== 1'b1 || bus.blk_ready !== 1'b1 || bus.busy !== 1'b0) begin
         failures++;
         $display("FAIL timeout at 80: err=%b ready=%b busy=%b, required 1 1 0", bus.err, bus.blk_ready, bus.busy);
      end
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.dig_valid !== 1'b0 || bus.err !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL timeout sticky: %0d bad cycles, required 0", bad);
      end
      core_hang = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      ref_chain = IV;
      checks++;
      if (bus.err !== 1'b0) begin
         failures++;
         $display("FAIL timeout clear: err=%b after reset, required 0", bus.err);
      end
   endtask
`endif

   initial begin
      bus.blk_valid = 1'b0;
      bus.blk_data  = '0;
      bus.blk_first = 1'b0;
      bus.blk_last  = 1'b0;
      bus.dig_ready = 1'b0;
      test_reset();
      test_abc();
      test_empty();
      test_two_block();
      test_dig_stall();
      test_reset_mid_expand();
      test_random();
`ifdef SHA256_HASH_CTRL_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
